// File: rtl/chroma_pkg.sv
// Shared chroma-key types, reset defaults and step helpers.
// Used by the key controller and by the chroma key datapath.
package chroma_pkg;

  typedef enum logic [1:0] {
    KEY_OFF   = 2'b00,
    KEY_GREEN = 2'b01,
    KEY_BLUE  = 2'b10
  } key_sel_t;

  typedef enum logic [1:0] {
    F_COLOR  = 2'd0,
    F_MIN    = 2'd1,
    F_MARGIN = 2'd2
  } edit_field_t;

  localparam logic [3:0] DEF_MIN_C    = 4'd5;
  localparam logic [3:0] DEF_MARGIN_C = 4'd3;

  // Colour cycles OFF -> GREEN -> BLUE -> OFF on up, reverse on down.
  function automatic key_sel_t col_step(key_sel_t c, logic up);
    case (c)
      KEY_OFF:   col_step = up ? KEY_GREEN : KEY_BLUE;
      KEY_GREEN: col_step = up ? KEY_BLUE  : KEY_OFF;
      default:   col_step = up ? KEY_OFF   : KEY_GREEN;
    endcase
  endfunction

  function automatic logic [3:0] sat_step(logic [3:0] v, logic up);
    if (up) sat_step = (v == 4'd15) ? v : v + 4'd1;
    else    sat_step = (v == 4'd0)  ? v : v - 4'd1;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with rise/fall detect on the registered pair.
// RST_VAL matches the input's idle level so reset release makes no edge.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise,
  output logic fall
);

  logic s1, s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
    end else begin
      s1 <= in;
      s2 <= s1;
    end
  end

  assign rise = s1 & ~s2;
  assign fall = ~s1 & s2;

endmodule

// File: rtl/chroma_key_ctrl.sv
// Button-driven chroma key config editor; working config is committed
// to the active outputs only at the start of vertical blanking.
module chroma_key_ctrl
  import chroma_pkg::*;
#(
  parameter logic [3:0] DEF_MIN    = DEF_MIN_C,
  parameter logic [3:0] DEF_MARGIN = DEF_MARGIN_C
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       v_sync,
  output logic [1:0] key_sel,
  output logic [3:0] key_min,
  output logic [3:0] key_margin,
  output logic       cfg_update,
  output logic [1:0] edit_field,
  output logic       dirty
);

  localparam int NUM_IN = 4;
  localparam int I_NEXT = 0, I_UP = 1, I_DOWN = 2, I_VS = 3;
  // v_sync idles high, buttons idle low.
  localparam logic [NUM_IN-1:0] SYNC_RST = 4'b1000;

  logic [NUM_IN-1:0] sync_in, rise, fall;
  assign sync_in = {v_sync, btn_down, btn_up, btn_next};

  for (genvar i = 0; i < NUM_IN; i++) begin : g_sync
    sync_edge #(.RST_VAL(SYNC_RST[i])) u_sync (
      .clk  (clk),
      .reset(reset),
      .in   (sync_in[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  logic unused_edges;
  assign unused_edges = ^{fall[I_DOWN:I_NEXT], rise[I_VS]};

  edit_field_t field_q, field_d;
  key_sel_t    w_col, w_col_d;
  logic [3:0]  w_min, w_min_d, w_mar, w_mar_d;
  logic        dirty_d, commit, edit;

  assign edit_field = field_q;

  always_comb begin
    field_d = field_q;
    if (rise[I_NEXT]) begin
      case (field_q)
        F_COLOR: field_d = F_MIN;
        F_MIN:   field_d = F_MARGIN;
        default: field_d = F_COLOR;
      endcase
    end
  end

  always_comb begin
    w_col_d = w_col;
    w_min_d = w_min;
    w_mar_d = w_mar;
    dirty_d = dirty;
    commit  = fall[I_VS] & dirty;
    // next wins; simultaneous up+down cancels out.
    edit    = ~rise[I_NEXT] & (rise[I_UP] ^ rise[I_DOWN]);
    if (commit) dirty_d = 1'b0;
    if (edit) begin
      case (field_q)
        F_COLOR: w_col_d = col_step(w_col, rise[I_UP]);
        F_MIN:   w_min_d = sat_step(w_min, rise[I_UP]);
        default: w_mar_d = sat_step(w_mar, rise[I_UP]);
      endcase
    end
    // Edit after commit keeps the new edit pending.
    if ({w_col_d, w_min_d, w_mar_d} != {w_col, w_min, w_mar}) dirty_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) field_q <= F_COLOR;
    else       field_q <= field_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_col      <= KEY_GREEN;
      w_min      <= DEF_MIN;
      w_mar      <= DEF_MARGIN;
      key_sel    <= KEY_GREEN;
      key_min    <= DEF_MIN;
      key_margin <= DEF_MARGIN;
      cfg_update <= 1'b0;
      dirty      <= 1'b0;
    end else begin
      w_col      <= w_col_d;
      w_min      <= w_min_d;
      w_mar      <= w_mar_d;
      dirty      <= dirty_d;
      cfg_update <= commit;
      if (commit) begin
        key_sel    <= w_col;
        key_min    <= w_min;
        key_margin <= w_mar;
      end
    end
  end

endmodule

// File: doc/chroma_key_ctrl.md
CHROMA_KEY_CTRL -- requirements
Module: chroma_key_ctrl

Interface
REQ-001 SHALL have parameter DEF_MIN, default 4'd5: reset value of the green/blue level threshold.
REQ-002 SHALL have parameter DEF_MARGIN, default 4'd3: reset value of the dominance margin over the other two channels.
REQ-003 SHALL have one clock and asynchronous active-high reset, as ports: clk input 1 (system clock); reset input 1 (asynchronous active-high reset).
REQ-004 SHALL have port btn_next input 1: debounced level button that advances the edit field.
REQ-005 SHALL have port btn_up input 1: debounced level button that increments the current field.
REQ-006 SHALL have port btn_down input 1: debounced level button that decrements the current field.
REQ-007 SHALL have port v_sync input 1: VGA vertical sync, active-low.
REQ-008 SHALL have port key_sel output 2: active key colour, using key_sel_t (OFF=00, GREEN=01, BLUE=10; 11 never driven).
REQ-009 SHALL have port key_min output 4: active threshold applied to the keyed channel.
REQ-010 SHALL have port key_margin output 4: active dominance margin.
REQ-011 SHALL have port cfg_update output 1: one-cycle pulse when the active config is loaded.
REQ-012 SHALL have port edit_field output 2: current edit field, using edit_field_t (F_COLOR=0, F_MIN=1, F_MARGIN=2).
REQ-013 SHALL have port dirty output 1: the working config differs from the active config and is pending commit.

Function
REQ-014 SHALL pass each of btn_next, btn_up, btn_down and v_sync through two flops (s1, s2); rise = s1 & ~s2 and fall = ~s1 & s2, both evaluated on the registered values.
REQ-015 SHALL perform every action at the clock edge after the one on which its edge is detected, giving a 2-cycle latency from input change to register update.
REQ-016 SHALL advance the edit FSM on a btn_next rise: F_COLOR -> F_MIN -> F_MARGIN -> F_COLOR; there is no other transition.
REQ-017 SHALL ignore btn_up and btn_down rises in a cycle where btn_next also rises (btn_next priority).
REQ-018 SHALL ignore a cycle in which btn_up and btn_down rise together; the working config is unchanged and dirty is unaffected.
REQ-019 In F_COLOR, SHALL step working colour on up OFF->GREEN->BLUE->OFF and on down the reverse, with wrap-around.
REQ-020 In F_MIN and F_MARGIN, SHALL increment or decrement the 4-bit working value with saturation at 0 and 15, with no wrap.
REQ-021 SHALL leave dirty unchanged on a saturated (no-change) step.
REQ-022 SHALL set dirty on any working-value change.
REQ-023 On a v_sync fall with dirty=1, SHALL copy working to active (key_sel, key_min, key_margin), pulse cfg_update for exactly 1 cycle, and clear dirty.
REQ-024 On a v_sync fall with dirty=0, SHALL take no action and keep cfg_update at 0.
REQ-025 When a commit and an edit fall in the same cycle, active SHALL take the pre-edit working values, working SHALL take the edit, and dirty SHALL remain 1.
REQ-026 SHALL change active outputs only in the commit cycle, i.e. only at frame-blanking start.
REQ-027 SHALL register all outputs.

Reset
REQ-028 While reset=1, SHALL hold key_sel=GREEN, key_min=DEF_MIN, key_margin=DEF_MARGIN, with working registers at the same values.
REQ-029 While reset=1, SHALL hold cfg_update=0, dirty=0, edit_field=F_COLOR.
REQ-030 SHALL reset button synchronizer flops to 0 and v_sync synchronizer flops to 1, so no spurious edge occurs after reset.
REQ-031 SHALL discard any edit or commit in progress when reset is asserted mid-operation; nothing is pending after release.

Structure
REQ-032 SHALL define key_sel_t, edit_field_t and the default constants in shared package chroma_pkg, imported by this block and the chroma key datapath.
REQ-033 SHALL implement synchronization and edge detection in one sub-module, sync_edge (ports: clk, reset, in, rise, fall; parameter RST_VAL), instantiated 4 times.

Verification
REQ-034 Reset release with no stimulus, then 3 v_sync falls -> key_sel=01, key_min=5, key_margin=3, dirty=0, cfg_update never 1.
REQ-035 btn_next rise, then btn_up x2 -> key_min stays 5 and dirty=1; next v_sync fall -> key_min=7 and a single 1-cycle cfg_update pulse 2 cycles after the fall.
REQ-036 F_MARGIN selected, btn_down x5 from 3 -> working margin 0 (saturated), dirty=1; after commit key_margin=0; a further btn_down leaves dirty=0.
REQ-037 F_COLOR selected, btn_up x3 -> working colour GREEN->BLUE->OFF->GREEN, dirty=1 (set on change); commit -> key_sel=01 with a cfg_update pulse.
REQ-038 btn_up rise timed into the same cycle as the v_sync-fall action with key_min working=6, active=5, dirty=1 -> key_min=6, working=7, dirty=1; next fall -> key_min=7.
REQ-039 btn_next and btn_up rising together -> edit_field advances and the value is unchanged; reset asserted while dirty=1 -> all defaults, with no cfg_update after release.
